// File: rtl/disp_scan_ctrl.sv
// Seven-segment scan sequencer: one digit per slot, with a blanking gap between slots.
// Build with DISP_SCAN_DIM_EN to add the 4-bit bright input that dims the digits.
module disp_scan_ctrl #(
  parameter int REFRESH_DIV  = 125000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] digit_mask,
`ifdef DISP_SCAN_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic [2:0] rd_addr,
  output logic [7:0] an_n,
  output logic       seg_blank,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] ON    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    rd_addr_q, rd_addr_d;
  logic [7:0]    an_n_q, an_n_d;
  logic          seg_blank_q, seg_blank_d;
  logic          frame_tick_q, frame_tick_d;

  logic [2:0]    nxt, first;
  logic          wrap, cur_on, lit;

`ifdef DISP_SCAN_DIM_EN
  localparam int SUB = (REFRESH_DIV - BLANK_CYCLES) / 16;
  logic [3:0] bright_q, bright_d;
`endif

  // Circular search starting after i; i itself is the last candidate.
  function automatic logic [2:0] next_idx(input logic [2:0] i, input logic [7:0] m);
    logic [2:0] j;
    logic       hit;
    next_idx = i;
    hit      = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      j = i + 3'(k);
      if (!hit && m[j]) begin
        next_idx = j;
        hit      = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] first_idx(input logic [7:0] m);
    first_idx = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (m[k]) first_idx = 3'(k);
  endfunction

  assign nxt    = next_idx(idx_q, digit_mask);
  assign first  = first_idx(digit_mask);
  assign wrap   = (nxt <= idx_q);
  assign cur_on = digit_mask[idx_q];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rd_addr_d    = rd_addr_q;
    frame_tick_d = 1'b0;
`ifdef DISP_SCAN_DIM_EN
    bright_d     = bright_q;
`endif
    // Disable outranks any mask or slot event.
    if (!en || digit_mask == 8'h00) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          idx_d     = first;
          rd_addr_d = first;
          cnt_d     = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d = '0;
            if (!cur_on) begin
              // Digit vanished while blanked: skip it and blank again.
              idx_d        = nxt;
              rd_addr_d    = nxt;
              frame_tick_d = wrap;
            end else begin
              state_d  = ON;
`ifdef DISP_SCAN_DIM_EN
              bright_d = bright;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (!cur_on || cnt_q == ON_LAST) begin
            state_d      = BLANK;
            cnt_d        = '0;
            idx_d        = nxt;
            rd_addr_d    = nxt;
            frame_tick_d = wrap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
`ifdef DISP_SCAN_DIM_EN
    lit = (state_d == ON) && (32'(cnt_d) < (32'(bright_d) + 32'd1) * 32'(SUB));
`else
    lit = (state_d == ON);
`endif
    an_n_d      = lit ? ~(8'd1 << idx_d) : 8'hFF;
    seg_blank_d = !lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      rd_addr_q    <= 3'd0;
      an_n_q       <= 8'hFF;
      seg_blank_q  <= 1'b1;
      frame_tick_q <= 1'b0;
`ifdef DISP_SCAN_DIM_EN
      bright_q     <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      an_n_q       <= an_n_d;
      seg_blank_q  <= seg_blank_d;
      frame_tick_q <= frame_tick_d;
`ifdef DISP_SCAN_DIM_EN
      bright_q     <= bright_d;
`endif
    end
  end

  assign rd_addr    = rd_addr_q;
  assign an_n       = an_n_q;
  assign seg_blank  = seg_blank_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a slot-time reference model queues expected outputs per cycle.
module tb_disp_scan_ctrl;
`ifdef DISP_SCAN_DIM_EN
  localparam int R = 34;
`else
  localparam int R = 10;
`endif
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] digit_mask = 8'h00;
  logic [3:0] bright = 4'd0;
  logic [2:0] rd_addr;
  logic [7:0] an_n;
  logic       seg_blank;
  logic       frame_tick;

  disp_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .digit_mask(digit_mask),
`ifdef DISP_SCAN_DIM_EN
    .bright(bright),
`endif
    .rd_addr(rd_addr),
    .an_n(an_n),
    .seg_blank(seg_blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] an;
    logic       blank;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   ticks = 0;

  task automatic chk(input string name, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a digit slot is R cycles long; it is dark for offsets < B.
  bit m_active;
  int m_idx, m_t, m_rd, m_bq;
  bit m_tick;

  function automatic int nxt_dig(input int i, input logic [7:0] m);
    for (int k = 1; k <= 8; k++)
      if (m[(i + k) % 8]) return (i + k) % 8;
    return i;
  endfunction

  function automatic int first_dig(input logic [7:0] m);
    for (int j = 0; j < 8; j++)
      if (m[j]) return j;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_t = 0; m_rd = 0; m_bq = 0; m_tick = 0;
  endtask

  task automatic advance(input logic [7:0] m);
    int n;
    n = nxt_dig(m_idx, m);
    m_tick = (n <= m_idx);
    m_idx = n;
    m_rd = n;
    m_t = 0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] m, input logic [3:0] b);
    exp_t x;
    bit   lit;
    m_tick = 0;
    if (!e || m == 8'h00) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_idx = first_dig(m);
      m_rd = m_idx;
      m_t = 0;
    end else if (!m[m_idx] && m_t >= B - 1) begin
      advance(m);
    end else if (m_t == R - 1) begin
      advance(m);
    end else begin
      m_t++;
      if (m_t == B) m_bq = int'(b);
    end
    lit = m_active && (m_t >= B);
`ifdef DISP_SCAN_DIM_EN
    lit = lit && ((m_t - B) < (m_bq + 1) * ((R - B) / 16));
`endif
    x.rd    = 3'(m_rd);
    x.an    = lit ? ~(8'd1 << m_idx) : 8'hFF;
    x.blank = !lit;
    x.tick  = m_tick;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic e, input logic [7:0] m, input logic [3:0] b);
    @(negedge clk);
    en = e; digit_mask = m; bright = b;
    model_step(e, m, b);
  endtask

  task automatic run(input int n, input logic e, input logic [7:0] m, input logic [3:0] b);
    for (int i = 0; i < n; i++) step(e, m, b);
  endtask

  task automatic drain();
    @(posedge clk); #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an_n"}, int'(an_n), 'hFF);
    chk({tag, "_seg_blank"}, int'(seg_blank), 1);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  // Monitor: every cycle the DUT presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (frame_tick) ticks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_addr", int'(rd_addr), int'(e.rd));
        chk("an_n", int'(an_n), int'(e.an));
        chk("seg_blank", int'(seg_blank), int'(e.blank));
        chk("frame_tick", int'(frame_tick), int'(e.tick));
      end
      chk("one_anode_max", ($countones(~an_n) <= 1) ? 1 : 0, 1);
      chk("lit_while_blank", (an_n != 8'hFF && seg_blank) ? 1 : 0, 0);
    end
  end

  initial begin
    int t0;
    logic [7:0] m;
    logic       e;
    model_reset();
    #7;
    chk_reset_vals("por");
    @(negedge clk); rst = 1'b0;

    // Full scan: two wraps expected within 2 frames plus slack.
    t0 = ticks;
    run(2 * 8 * R + 10, 1'b1, 8'hFF, 4'd15);
    drain();
    chk("full_scan_ticks", ticks - t0, (2 * 8 * R + 9) / (8 * R));

    // Sparse mask: only digits 0 and 7.
    run(2, 1'b0, 8'hFF, 4'd0);
    drain();
    t0 = ticks;
    run(5 * 2 * R, 1'b1, 8'h81, 4'd15);
    drain();
    chk("sparse_ticks", ticks - t0, (10 * R - 1) / (2 * R));

    // Mid-slot drop of digit 3 while it is lit.
    run(2, 1'b0, 8'hFF, 4'd0);
    run(3 * R + B + 2, 1'b1, 8'hFF, 4'd7);
    drain();
    chk("digit3_lit", int'(an_n), 'hF7);
    run(3 * R, 1'b1, 8'hF7, 4'd7);

    // Disable mid-slot, re-enable at digit 2, then empty mask.
    run(3, 1'b0, 8'hF7, 4'd7);
    run(B + 1, 1'b1, 8'h24, 4'd15);
    drain();
    chk("restart_digit2", int'(an_n), 'hFB);
    run(3 * R, 1'b1, 8'h24, 4'd0);
    run(10, 1'b1, 8'h00, 4'd3);

    // Async reset in the middle of a lit slot.
    run(2 * R + B + 3, 1'b1, 8'hFF, 4'd15);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    repeat (3) @(negedge clk);
    en = 1'b0; digit_mask = 8'h00;
    model_reset();
    rst = 1'b0;

    // Brightness extremes over a single lit digit.
    run(3 * R, 1'b1, 8'h10, 4'd0);
    run(3 * R, 1'b1, 8'h10, 4'd15);
    run(3 * R, 1'b1, 8'h0C, 4'd8);

    // Random mask churn, occasional disable, random brightness.
    m = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom) | (8'($urandom) & 8'($urandom));
      e = ($urandom_range(0, 63) != 0);
      step(e, m, 4'($urandom));
    end
    drain();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
Name:
disp_scan_ctrl

Overview:
- Time-multiplexed scan sequencer for the 8-digit seven-segment display.
- Selects one digit at a time and drives the read address of the 8x4 digit register file, whose output feeds the segment decoder.
- Drives active-low anodes and inserts a blanking interval between digits to prevent ghosting.
- Skips digits that are masked off and flags frame completion.

Parameters:
- REFRESH_DIV, 125000: clock cycles per digit slot (blank + on). Must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles per slot with all anodes off. Must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  1 = scanning enabled
- digit_mask  in  8  bit i = 1 means digit i participates in the scan
- rd_addr  out  3  register-file read address (current digit)
- an_n  out  8  active-low anodes; bit i drives ANi
- seg_blank  out  1  1 = force segments off
- frame_tick  out  1  one-cycle pulse on wrap from highest to lowest enabled digit

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, idx=0, slot counter=0, rd_addr=0, an_n=8'hFF, seg_blank=1, frame_tick=0. All outputs are registered.
- next(i): first set bit of digit_mask searched circularly from i+1. Bit i itself is checked last. If only bit i is set, next(i)=i.
- first: lowest set bit of digit_mask.
- IDLE:
  - an_n=FF, seg_blank=1.
  - If en=1 and digit_mask!=0: idx<=first, rd_addr<=first, counter<=0, go to BLANK.
- BLANK:
  - an_n=FF, seg_blank=1, rd_addr=idx, so the register-file read settles before the digit is lit.
  - After BLANK_CYCLES cycles, go to ON.
- ON:
  - an_n has bit idx low and all other bits high; seg_blank=0.
  - Lasts REFRESH_DIV-BLANK_CYCLES cycles.
  - At the end: idx<=next(idx), rd_addr follows, go to BLANK.
  - frame_tick=1 for that one cycle if next(idx)<=idx.
- Slot period is exactly REFRESH_DIV cycles per enabled digit. Frame period is REFRESH_DIV × popcount(digit_mask).
- Mask changes:
  - Sampled every cycle.
  - If digit_mask[idx] drops during ON: end the slot on the next cycle (an_n=FF), idx<=next(idx), go to BLANK. frame_tick follows the same wrap rule.
  - Dropping a digit during BLANK: at BLANK exit, re-evaluate to next(idx) and restart BLANK.
- Disable: en=0 or digit_mask==0 in any state → IDLE on the next edge, an_n=FF, seg_blank=1. idx is retained but unused; re-entry always starts at first.
- Priority: disable beats mask-drop, and mask-drop beats normal slot end.
- Async reset mid-slot: an_n goes to FF immediately, without waiting for a clock edge.
- At most one anode is ever low. An anode low with seg_blank=1 is illegal.

Optional Feature:
- Macro: DISP_SCAN_DIM_EN.
- When defined:
  - Adds input bright [3:0].
  - The ON window is divided into 16 equal sub-periods, integer floor of (REFRESH_DIV-BLANK_CYCLES)/16; remainder cycles count as off.
  - The anode is low only for the first (bright+1) sub-periods; anodes are FF and seg_blank=1 for the remainder.
  - bright is sampled at ON entry. Slot timing and frame_tick are unchanged.
- When undefined: no bright port; the anode is on for the full ON window.

Test Plan:
All scenarios use REFRESH_DIV=10, BLANK_CYCLES=2.
- Reset: assert rst mid-run → an_n=FF, seg_blank=1, rd_addr=0, frame_tick=0 asynchronously.
- Full scan: en=1, mask=FF → an_n=FF for 2 cycles (rd_addr=0), then FE for 8, FF for 2 (rd_addr=1), then FD, and so on through 7F. frame_tick pulses once every 80 cycles at the 7→0 transition.
- Sparse mask: mask=8'h81 → digits 0 and 7 alternate with a 20-cycle frame. frame_tick fires at 7→0 only. rd_addr shows only 0 and 7.
- Mid-slot mask drop: during ON of digit 3 (an_n=F7), clear mask bit 3 → an_n=FF next cycle, BLANK for 2 cycles, then digit 4 lit (EF).
- Disable: en=0 during ON → an_n=FF next cycle. Re-enable with mask=8'h24 → scan restarts at digit 2 (FB after 2 blank cycles). mask=00 → stays IDLE.
- DISP_SCAN_DIM_EN defined with REFRESH_DIV=34, BLANK_CYCLES=2 (sub-period 2 cycles):
  - bright=0 → anode low 2 of 32 ON cycles.
  - bright=15 → low all 32.
  - Slot period stays 34 cycles.
